// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared state encoding, ASCII constants and input normalisers for id_gen
package id_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LETTER = 2'd1,
        ST_DIGIT  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_A_UP = 8'h41;
    localparam logic [7:0] ASCII_A_LO = 8'h61;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam int         LETTERS    = 26;
    localparam int         DIGITS     = 10;

    // Out-of-range starting points fall back to 'a' / '0'.
    function automatic logic [4:0] norm_letter(input logic [4:0] b);
        return (b >= 5'(LETTERS)) ? 5'd0 : b;
    endfunction

    function automatic logic [3:0] norm_digit(input logic [3:0] b);
        return (b >= 4'(DIGITS)) ? 4'd0 : b;
    endfunction

endpackage

// File: rtl/id_char_inc.sv
// rtl/id_char_inc.sv - modulo-MOD wrap incrementer for a character index
module id_char_inc #(
    parameter int W   = 5,
    parameter int MOD = 26
) (
    input  logic [W-1:0] idx_i,
    output logic [W-1:0] next_o
);

    always_comb begin
        if (idx_i >= W'(MOD - 1)) begin
            next_o = '0;
        end else begin
            next_o = idx_i + W'(1);
        end
    end

endmodule

// File: rtl/id_gen.sv
// rtl/id_gen.sv - emits a letters-then-digits ASCII identifier one char per handshake
module id_gen
    import id_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] letter_cnt,
    input  logic [3:0] digit_cnt,
    input  logic [4:0] base_letter,
    input  logic       upper,
    input  logic [3:0] base_digit,
    input  logic       ready,
    output logic [7:0] char,
    output logic       valid,
    output logic       last,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_e     state_q, state_d;
    logic [4:0] let_idx_q, let_idx_d;
    logic [3:0] dig_idx_q, dig_idx_d;
    logic [3:0] let_rem_q, let_rem_d;
    logic [3:0] dig_rem_q, dig_rem_d;
    logic       upper_q, upper_d;
    logic       err_q, err_d;
    logic [4:0] let_inc;
    logic [3:0] dig_inc;

    id_char_inc #(.W(5), .MOD(LETTERS)) u_let_inc (
        .idx_i  (let_idx_q),
        .next_o (let_inc)
    );

    id_char_inc #(.W(4), .MOD(DIGITS)) u_dig_inc (
        .idx_i  (dig_idx_q),
        .next_o (dig_inc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            let_idx_q <= '0;
            dig_idx_q <= '0;
            let_rem_q <= '0;
            dig_rem_q <= '0;
            upper_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            let_idx_q <= let_idx_d;
            dig_idx_q <= dig_idx_d;
            let_rem_q <= let_rem_d;
            dig_rem_q <= dig_rem_d;
            upper_q   <= upper_d;
            err_q     <= err_d;
        end
    end

    // Request inputs are only looked at in IDLE; while busy they are ignored.
    always_comb begin
        state_d   = state_q;
        let_idx_d = let_idx_q;
        dig_idx_d = dig_idx_q;
        let_rem_d = let_rem_q;
        dig_rem_d = dig_rem_q;
        upper_d   = upper_q;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (letter_cnt != 4'd0) begin
                        state_d   = ST_LETTER;
                        let_idx_d = norm_letter(base_letter);
                        dig_idx_d = norm_digit(base_digit);
                        let_rem_d = letter_cnt;
                        dig_rem_d = digit_cnt;
                        upper_d   = upper;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LETTER: begin
                if (ready) begin
                    let_idx_d = let_inc;
                    let_rem_d = let_rem_q - 4'd1;
                    if (let_rem_q == 4'd1) begin
                        state_d = (dig_rem_q != 4'd0) ? ST_DIGIT : ST_DONE;
                    end
                end
            end
            ST_DIGIT: begin
                if (ready) begin
                    dig_idx_d = dig_inc;
                    dig_rem_d = dig_rem_q - 4'd1;
                    if (dig_rem_q == 4'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        char  = 8'h00;
        valid = 1'b0;
        last  = 1'b0;
        busy  = (state_q != ST_IDLE);
        done  = (state_q == ST_DONE);
        err   = err_q;
        case (state_q)
            ST_LETTER: begin
                valid = 1'b1;
                char  = (upper_q ? ASCII_A_UP : ASCII_A_LO) + {3'b000, let_idx_q};
                last  = (let_rem_q == 4'd1) && (dig_rem_q == 4'd0);
            end
            ST_DIGIT: begin
                valid = 1'b1;
                char  = ASCII_0 + {4'b0000, dig_idx_q};
                last  = (dig_rem_q == 4'd1);
            end
            default: begin
                char = 8'h00;
            end
        endcase
    end

endmodule
